sync_fifo: RTL and testbench

//  Parametrised single-clock FIFO, successor to the dual-clock cdc_fifo, for

---
 rtl/sync_fifo.sv | 157 +++++++++++++++
 tb/tb_sync_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with an occupancy
//               count, almost-full/almost-empty flags and a synchronous flush.
//               The head entry is always presented on read_data (0 while
//               empty). Every output is decoded from registered state only.
// Ports       : clock, reset (async, active-high), flush (sync clear)
//               write_data / write_increment      -> push side
//               read_increment / read_data        -> pop side
//               full, almost_full, empty, almost_empty, level -> status
//               overflow, underflow               -> sticky error flags
//                                                    (SYNC_FIFO_ERROR_FLAGS_EN)
// Config      : define SYNC_FIFO_ERROR_FLAGS_EN to add the overflow/underflow
//               outputs; without it rejected requests are silently ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH             = 4,
    parameter int ADDRESS_WIDTH          = 5,
    parameter int ALMOST_FULL_THRESHOLD  = 28,
    parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_increment,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     read_increment,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   level
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int                   c_DEPTH     = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] c_DEPTH_L = (ADDRESS_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] c_ONE     = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH:0] c_AF_L    = (ADDRESS_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [ADDRESS_WIDTH:0] c_AE_L    = (ADDRESS_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);

    // Thresholds must lie within 0..depth; anything else is a build error.
    generate
        if (ALMOST_FULL_THRESHOLD < 0 || ALMOST_FULL_THRESHOLD > c_DEPTH) begin : g_af_range_error
            $error("sync_fifo: ALMOST_FULL_THRESHOLD out of range 0..2**ADDRESS_WIDTH");
        end
        if (ALMOST_EMPTY_THRESHOLD < 0 || ALMOST_EMPTY_THRESHOLD > c_DEPTH) begin : g_ae_range_error
            $error("sync_fifo: ALMOST_EMPTY_THRESHOLD out of range 0..2**ADDRESS_WIDTH");
        end
    endgenerate

    // Pointers carry one extra MSB so they wrap naturally; storage uses the
    // low ADDRESS_WIDTH bits.
    logic [ADDRESS_WIDTH:0]  write_ptr_q, write_ptr_d;
    logic [ADDRESS_WIDTH:0]  read_ptr_q,  read_ptr_d;
    logic [ADDRESS_WIDTH:0]  level_q,     level_d;
    logic [DATA_WIDTH-1:0]   mem_q [c_DEPTH];

    logic                    w_push;
    logic                    w_pop;

    // Status flags decode the registered level only.
    assign full         = (level_q == c_DEPTH_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= c_AF_L);
    assign almost_empty = (level_q <= c_AE_L);
    assign level        = level_q;

    // Head entry is forced to zero while empty so stale storage never leaks.
    assign read_data = empty ? '0 : mem_q[read_ptr_q[ADDRESS_WIDTH-1:0]];

    // Acceptance uses full/empty as they stand at the start of the cycle, so
    // a push into an empty FIFO never bypasses to a same-cycle pop.
    assign w_push = write_increment && !full;
    assign w_pop  = read_increment  && !empty;

    always_comb begin
        write_ptr_d = write_ptr_q;
        read_ptr_d  = read_ptr_q;
        level_d     = level_q;
        if (flush) begin
            write_ptr_d = '0;
            read_ptr_d  = '0;
            level_d     = '0;
        end else begin
            if (w_push) begin
                write_ptr_d = write_ptr_q + c_ONE;
            end
            if (w_pop) begin
                read_ptr_d = read_ptr_q + c_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + c_ONE;
                2'b01:   level_d = level_q - c_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_ptr_q <= '0;
            read_ptr_q  <= '0;
            level_q     <= '0;
        end else begin
            write_ptr_q <= write_ptr_d;
            read_ptr_q  <= read_ptr_d;
            level_q     <= level_d;
        end
    end

    // Storage is deliberately not reset; flush also leaves it untouched.
    always_ff @(posedge clock) begin
        if (w_push && !flush) begin
            mem_q[write_ptr_q[ADDRESS_WIDTH-1:0]] <= write_data;
        end
    end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            overflow_d  = overflow_q  | (write_increment && full);
            underflow_d = underflow_q | (read_increment  && empty);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. A queue model holds the
//               expected contents; entries are pushed when a write is driven
//               and popped/compared against read_data when a read is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_DW    = 4;
    localparam int c_AW    = 5;
    localparam int c_DEPTH = 32;

    logic              clock;
    logic              reset;
    logic              flush;
    logic [c_DW-1:0]   write_data;
    logic              write_increment;
    logic              full;
    logic              almost_full;
    logic              read_increment;
    logic [c_DW-1:0]   read_data;
    logic              empty;
    logic              almost_empty;
    logic [c_AW:0]     level;
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    logic              overflow;
    logic              underflow;
`endif

    sync_fifo #(
        .DATA_WIDTH             (c_DW),
        .ADDRESS_WIDTH          (c_AW),
        .ALMOST_FULL_THRESHOLD  (28),
        .ALMOST_EMPTY_THRESHOLD (4)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .write_data      (write_data),
        .write_increment (write_increment),
        .full            (full),
        .almost_full     (almost_full),
        .read_increment  (read_increment),
        .read_data       (read_data),
        .empty           (empty),
        .almost_empty    (almost_empty),
        .level           (level)
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        ,
        .overflow        (overflow),
        .underflow       (underflow)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [c_DW-1:0]  model_q[$];
    logic             ovf_exp  = 1'b0;
    logic             unf_exp  = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_state(input string pfx);
        int              sz;
        logic [c_DW-1:0] head;
        sz   = model_q.size();
        head = (sz > 0) ? model_q[0] : '0;
        check_value({pfx, "_level"},        32'(level),        32'(sz));
        check_value({pfx, "_empty"},        32'(empty),        32'(sz == 0));
        check_value({pfx, "_full"},         32'(full),         32'(sz == c_DEPTH));
        check_value({pfx, "_almost_empty"}, 32'(almost_empty), 32'(sz <= 4));
        check_value({pfx, "_almost_full"},  32'(almost_full),  32'(sz >= 28));
        check_value({pfx, "_read_data"},    32'(read_data),    32'(head));
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        check_value({pfx, "_overflow"},     32'(overflow),     32'(ovf_exp));
        check_value({pfx, "_underflow"},    32'(underflow),    32'(unf_exp));
`endif
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic wr, input logic [c_DW-1:0] d, input logic rd, input logic fl);
        int              sz;
        logic [c_DW-1:0] obs_head;
        logic [c_DW-1:0] exp_head;
        check_state("cyc");
        sz       = model_q.size();
        obs_head = read_data;
        write_increment = wr;
        write_data      = d;
        read_increment  = rd;
        flush           = fl;
        @(posedge clock);
        #1;
        write_increment = 1'b0;
        read_increment  = 1'b0;
        flush           = 1'b0;
        if (fl) begin
            model_q.delete();
            ovf_exp = 1'b0;
            unf_exp = 1'b0;
        end else begin
            if (rd && sz > 0) begin
                exp_head = model_q.pop_front();
                check_value("pop_data", 32'(obs_head), 32'(exp_head));
            end
            if (rd && sz == 0) unf_exp = 1'b1;
            if (wr && sz < c_DEPTH) model_q.push_back(d);
            if (wr && sz == c_DEPTH) ovf_exp = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic            r_wr;
        logic            r_rd;
        logic [c_DW-1:0] r_d;

        reset           = 1'b1;
        flush           = 1'b0;
        write_data      = '0;
        write_increment = 1'b0;
        read_increment  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_state("reset");
        reset = 1'b0;

        // 1: five pushes after reset
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        check_value("t1_level", 32'(level), 32'd5);
        check_value("t1_read_data", 32'(read_data), 32'h1);
        check_value("t1_almost_empty", 32'(almost_empty), 32'd0);

        // 2: fill from empty to 32, then one rejected push
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 4'(i), 1'b0, 1'b0);
            if (i == 26) check_value("t2_af_after27", 32'(almost_full), 32'd0);
            if (i == 27) check_value("t2_af_after28", 32'(almost_full), 32'd1);
        end
        check_value("t2_full", 32'(full), 32'd1);
        check_value("t2_level", 32'(level), 32'd32);
        step(1'b1, 4'hF, 1'b0, 1'b0);
        check_value("t2_level_after_ovf", 32'(level), 32'd32);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        check_value("t2_overflow", 32'(overflow), 32'd1);
`endif

        // 3: drain in order, then one rejected pop
        for (int i = 0; i < 32; i++) begin
            check_value("t3_order", 32'(read_data), 32'(i % 16));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check_value("t3_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check_value("t3_level_after_unf", 32'(level), 32'd0);
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
        check_value("t3_underflow", 32'(underflow), 32'd1);
`endif

        // 4: simultaneous push+pop at level 0, 10, 32, then random wrap run
        step(1'b1, 4'hA, 1'b1, 1'b0);
        check_value("t4_level_from0", 32'(level), 32'd1);
        for (int i = 0; i < 9; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
        step(1'b1, 4'h7, 1'b1, 1'b0);
        check_value("t4_level_from10", 32'(level), 32'd10);
        for (int i = 0; i < 22; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        check_value("t4_full_before", 32'(full), 32'd1);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        check_value("t4_level_from32", 32'(level), 32'd31);
        for (int i = 0; i < 200; i++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_rd = 1'($urandom_range(0, 1));
            r_d  = 4'($urandom_range(0, 15));
            step(r_wr, r_d, r_rd, 1'b0);
        end

        // 5: flush with push asserted at level 7
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 4'(i + 8), 1'b0, 1'b0);
        check_value("t5_level_before", 32'(level), 32'd7);
        step(1'b1, 4'h3, 1'b0, 1'b1);
        check_value("t5_level", 32'(level), 32'd0);
        check_value("t5_empty", 32'(empty), 32'd1);
        check_value("t5_read_data", 32'(read_data), 32'd0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        check_value("t5_head_after", 32'(read_data), 32'h9);

        // 6: asynchronous reset mid-burst at level 12
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b0);
        check_value("t6_level_before", 32'(level), 32'd12);
        #2;
        reset = 1'b1;
        #1;
        model_q.delete();
        ovf_exp = 1'b0;
        unf_exp = 1'b0;
        check_value("t6_level_async", 32'(level), 32'd0);
        check_value("t6_empty_async", 32'(empty), 32'd1);
        check_state("t6_async");
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 4), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check_state("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
